// File: rtl/frog_pkg.sv
// Shared definitions for the frogger frog controller and the renderer:
// grid geometry, start cell, game state and move encodings.
package frog_pkg;

    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;
    localparam int COL_W     = $clog2(GRID_COLS);
    localparam int ROW_W     = $clog2(GRID_ROWS);

    // The frog (re)spawns bottom-centre.
    localparam int START_COL = GRID_COLS / 2;
    localparam int START_ROW = GRID_ROWS - 1;

    typedef enum logic [1:0] {
        PLAY      = 2'b00,
        RESPAWN   = 2'b01,
        GAME_OVER = 2'b10
    } game_state_t;

    typedef enum logic [2:0] {
        MOVE_NONE,
        MOVE_LEFT,
        MOVE_DOWN,
        MOVE_UP,
        MOVE_RIGHT
    } move_t;

endpackage

// File: rtl/frog_hit_detect.sv
// Combinational frog/car overlap test over a packed car position bus.
// Also used by the renderer to highlight overlapping cells.
module frog_hit_detect #(
    parameter int NUM_CARS = 16,
    parameter int COL_W    = 5,
    parameter int ROW_W    = 4
) (
    input  logic [COL_W-1:0]          frog_col,
    input  logic [ROW_W-1:0]          frog_row,
    input  logic [NUM_CARS*COL_W-1:0] car_x,
    input  logic [NUM_CARS*ROW_W-1:0] car_y,
    output logic                      hit
);

    // NOTE: the default is assigned before the loop so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (car_x[i*COL_W +: COL_W] == frog_col &&
                car_y[i*ROW_W +: ROW_W] == frog_row) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frog_controller_n.sv
// Frog controller: position, lives, score and game state, with one move per
// button press, a respawn invulnerability window, goal scoring and game over.
module frog_controller_n #(
    parameter int GRID_COLS     = frog_pkg::GRID_COLS,
    parameter int GRID_ROWS     = frog_pkg::GRID_ROWS,
    parameter int NUM_CARS      = 16,
    parameter int MAX_LIVES     = 3,
    parameter int INVULN_CYCLES = 25000000,
    parameter int SCORE_W       = 8,
    parameter int COL_W         = $clog2(GRID_COLS),
    parameter int ROW_W         = $clog2(GRID_ROWS),
    parameter int LIVES_W       = $clog2(MAX_LIVES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_left,
    input  logic                      btn_down,
    input  logic                      btn_up,
    input  logic                      btn_right,
    input  logic                      restart,
    input  logic [NUM_CARS*COL_W-1:0] car_x,
    input  logic [NUM_CARS*ROW_W-1:0] car_y,
    output logic [COL_W-1:0]          frog_col,
    output logic [ROW_W-1:0]          frog_row,
    output logic [LIVES_W-1:0]        lives,
    output logic [SCORE_W-1:0]        score,
    output logic [1:0]                game_state,
    output logic                      invulnerable,
    output logic                      hit_pulse,
    output logic                      goal_pulse
);

    import frog_pkg::*;

    localparam int CNT_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;

    localparam logic [COL_W-1:0]   HOME_COL   = COL_W'(GRID_COLS / 2);
    localparam logic [ROW_W-1:0]   HOME_ROW   = ROW_W'(GRID_ROWS - 1);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(GRID_COLS - 1);
    localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(MAX_LIVES);
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(INVULN_CYCLES - 1);

    game_state_t      state;
    logic [CNT_W-1:0] invuln_cnt;
    logic             armed;
    logic             hit;
    logic             any_btn;
    logic             move_ok;
    move_t            move;

    frog_hit_detect #(
        .NUM_CARS (NUM_CARS),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W)
    ) u_hit_detect (
        .frog_col (frog_col),
        .frog_row (frog_row),
        .car_x    (car_x),
        .car_y    (car_y),
        .hit      (hit)
    );

    assign any_btn      = btn_left | btn_down | btn_up | btn_right;
    assign game_state   = state;
    assign invulnerable = (state == RESPAWN);

    always_comb begin
        move = MOVE_NONE;
        if (btn_left)       move = MOVE_LEFT;
        else if (btn_down)  move = MOVE_DOWN;
        else if (btn_up)    move = MOVE_UP;
        else if (btn_right) move = MOVE_RIGHT;
    end

    // A move off the grid is dropped without consuming the press.
    always_comb begin
        move_ok = 1'b0;
        case (move)
            MOVE_LEFT:  move_ok = (frog_col != '0);
            MOVE_DOWN:  move_ok = (frog_row != HOME_ROW);
            MOVE_UP:    move_ok = (frog_row != '0);
            MOVE_RIGHT: move_ok = (frog_col != LAST_COL);
            default:    move_ok = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frog_col   <= HOME_COL;
            frog_row   <= HOME_ROW;
            lives      <= FULL_LIVES;
            score      <= '0;
            state      <= PLAY;
            invuln_cnt <= '0;
            armed      <= 1'b1;
            hit_pulse  <= 1'b0;
            goal_pulse <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            goal_pulse <= 1'b0;
            if (restart) begin
                frog_col   <= HOME_COL;
                frog_row   <= HOME_ROW;
                lives      <= FULL_LIVES;
                score      <= '0;
                state      <= PLAY;
                invuln_cnt <= '0;
                armed      <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (!any_btn) armed <= 1'b1;
                        if (hit) begin
                            hit_pulse <= 1'b1;
                            frog_col  <= HOME_COL;
                            frog_row  <= HOME_ROW;
                            if (lives > LIVES_W'(1)) begin
                                lives      <= lives - 1'b1;
                                state      <= RESPAWN;
                                invuln_cnt <= CNT_LOAD;
                            end else begin
                                lives <= '0;
                                state <= GAME_OVER;
                            end
                        end else if (frog_row == '0) begin
                            goal_pulse <= 1'b1;
                            frog_col   <= HOME_COL;
                            frog_row   <= HOME_ROW;
                            if (score != '1) score <= score + 1'b1;
                        end else if (armed && move_ok) begin
                            armed <= 1'b0;
                            case (move)
                                MOVE_LEFT:  frog_col <= frog_col - 1'b1;
                                MOVE_DOWN:  frog_row <= frog_row + 1'b1;
                                MOVE_UP:    frog_row <= frog_row - 1'b1;
                                MOVE_RIGHT: frog_col <= frog_col + 1'b1;
                                default:    ;
                            endcase
                        end
                    end
                    RESPAWN: begin
                        armed <= 1'b0;
                        if (invuln_cnt == '0) state <= PLAY;
                        else                  invuln_cnt <= invuln_cnt - 1'b1;
                    end
                    GAME_OVER: begin
                        frog_col <= HOME_COL;
                        frog_row <= HOME_ROW;
                        lives    <= '0;
                    end
                    default: state <= PLAY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frog_controller_n.sv
// Scoreboard bench for frog_controller_n: a game-rule model queues the expected
// outputs for every clock edge and a monitor compares them after the edge.
module tb_frog_controller_n;

    localparam int NC   = 16;
    localparam int CW   = 5;
    localparam int RW   = 4;
    localparam int LW   = 2;
    localparam int SW   = 8;
    localparam int INV  = 8;
    localparam int MAXL = 3;
    localparam int COLS = 20;
    localparam int ROWS = 15;
    localparam int HOME_C = COLS / 2;
    localparam int HOME_R = ROWS - 1;
    localparam int ST_PLAY = 0, ST_RESP = 1, ST_OVER = 2;
    localparam int LEFT = 0, DOWN = 1, UP = 2, RIGHT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_left = 1'b0, btn_down = 1'b0, btn_up = 1'b0, btn_right = 1'b0;
    logic restart = 1'b0;
    logic [NC*CW-1:0] car_x;
    logic [NC*RW-1:0] car_y;
    logic [CW-1:0] frog_col;
    logic [RW-1:0] frog_row;
    logic [LW-1:0] lives;
    logic [SW-1:0] score;
    logic [1:0]    game_state;
    logic          invulnerable, hit_pulse, goal_pulse;

    int car_c[NC];
    int car_r[NC];

    typedef struct {
        int col;
        int row;
        int lives;
        int score;
        int st;
        bit inv;
        bit hit;
        bit goal;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Game-rule model
    int m_col, m_row, m_lives, m_score, m_state, m_resp_end, edge_n;
    bit m_armed, m_hit, m_goal;

    frog_controller_n #(
        .GRID_COLS     (COLS),
        .GRID_ROWS     (ROWS),
        .NUM_CARS      (NC),
        .MAX_LIVES     (MAXL),
        .INVULN_CYCLES (INV),
        .SCORE_W       (SW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left     (btn_left),
        .btn_down     (btn_down),
        .btn_up       (btn_up),
        .btn_right    (btn_right),
        .restart      (restart),
        .car_x        (car_x),
        .car_y        (car_y),
        .frog_col     (frog_col),
        .frog_row     (frog_row),
        .lives        (lives),
        .score        (score),
        .game_state   (game_state),
        .invulnerable (invulnerable),
        .hit_pulse    (hit_pulse),
        .goal_pulse   (goal_pulse)
    );

    always #5 clk = ~clk;

    always_comb begin
        car_x = '0;
        car_y = '0;
        for (int i = 0; i < NC; i++) begin
            car_x[i*CW +: CW] = CW'(car_c[i]);
            car_y[i*RW +: RW] = RW'(car_r[i]);
        end
    end

    function automatic exp_t snapshot();
        exp_t e;
        e.col   = m_col;
        e.row   = m_row;
        e.lives = m_lives;
        e.score = m_score;
        e.st    = m_state;
        e.inv   = (m_state == ST_RESP);
        e.hit   = m_hit;
        e.goal  = m_goal;
        return e;
    endfunction

    function automatic bit car_on(input int c, input int r);
        for (int i = 0; i < NC; i++)
            if (car_c[i] == c && car_r[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_col = HOME_C; m_row = HOME_R; m_lives = MAXL; m_score = 0;
        m_state = ST_PLAY; m_armed = 1'b1; m_hit = 1'b0; m_goal = 1'b0;
    endtask

    // Apply the game rules for the coming clock edge to the current inputs.
    task automatic model_edge();
        bit any;
        int nc, nr;
        any = btn_left | btn_down | btn_up | btn_right;
        edge_n++;
        m_hit  = 1'b0;
        m_goal = 1'b0;
        if (reset) begin
            model_reset();
        end else if (restart) begin
            m_lives = MAXL; m_score = 0; m_col = HOME_C; m_row = HOME_R;
            m_state = ST_PLAY; m_armed = 1'b0;
        end else if (m_state == ST_PLAY) begin
            if (car_on(m_col, m_row)) begin
                m_hit = 1'b1; m_col = HOME_C; m_row = HOME_R;
                if (m_lives > 1) begin
                    m_lives--; m_state = ST_RESP; m_resp_end = edge_n + INV;
                end else begin
                    m_lives = 0; m_state = ST_OVER;
                end
            end else if (m_row == 0) begin
                m_goal = 1'b1; m_col = HOME_C; m_row = HOME_R;
                if (m_score < (1 << SW) - 1) m_score++;
            end else if (m_armed && any) begin
                nc = m_col; nr = m_row;
                if (btn_left)      nc--;
                else if (btn_down) nr++;
                else if (btn_up)   nr--;
                else               nc++;
                if (nc >= 0 && nc < COLS && nr >= 0 && nr < ROWS) begin
                    m_col = nc; m_row = nr; m_armed = 1'b0;
                end
            end
            if (!any) m_armed = 1'b1;
        end else if (m_state == ST_RESP) begin
            m_armed = 1'b0;
            if (edge_n >= m_resp_end) m_state = ST_PLAY;
        end
        sb.push_back(snapshot());
    endtask

    task automatic check(input string name, input exp_t e);
        bit bad;
        vectors++;
        bad = (int'(frog_col) != e.col) || (int'(frog_row) != e.row) ||
              (int'(lives) != e.lives) || (int'(score) != e.score) ||
              (int'(game_state) != e.st) || (invulnerable != e.inv) ||
              (hit_pulse != e.hit) || (goal_pulse != e.goal);
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got col=%0d row=%0d lives=%0d score=%0d state=%0d inv=%0d hit=%0d goal=%0d; want col=%0d row=%0d lives=%0d score=%0d state=%0d inv=%0d hit=%0d goal=%0d",
                     name, frog_col, frog_row, lives, score, game_state, invulnerable, hit_pulse, goal_pulse,
                     e.col, e.row, e.lives, e.score, e.st, e.inv, e.hit, e.goal);
        end
    endtask

    // Monitor: one expected snapshot per clock edge
    initial begin
        int n = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("edge %0d", n), e);
                n++;
            end
        end
    end

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_btn(input bit l, input bit d, input bit u, input bit r);
        btn_left = l; btn_down = d; btn_up = u; btn_right = r;
    endtask

    task automatic press(input int dir);
        set_btn(dir == LEFT, dir == DOWN, dir == UP, dir == RIGHT);
        tick();
        set_btn(0, 0, 0, 0);
        tick();
    endtask

    task automatic cars_off();
        for (int i = 0; i < NC; i++) begin
            car_c[i] = 31;
            car_r[i] = 15;
        end
    endtask

    task automatic restart_game();
        set_btn(0, 0, 0, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        edge_n = 0;
        m_resp_end = 0;
        cars_off();
        model_reset();

        // Reset held over two edges, then released
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Three separate presses, then one long hold
        repeat (3) press(UP);
        set_btn(0, 0, 1, 0);
        repeat (10) tick();
        set_btn(0, 0, 0, 0);
        tick();

        // Left beats right; left edge is ignored without disarming
        restart_game();
        set_btn(1, 0, 0, 1);
        tick();
        set_btn(0, 0, 0, 0);
        tick();
        repeat (9) press(LEFT);
        set_btn(1, 0, 0, 0);
        tick();
        set_btn(0, 0, 0, 1);
        tick();
        set_btn(0, 0, 0, 0);
        tick();
        press(DOWN);
        press(UP);

        // Three hits to game over; first respawn also sees a car on the start cell
        restart_game();
        for (int h = 0; h < 3; h++) begin
            car_c[0] = HOME_C; car_r[0] = HOME_R - 1;
            press(UP);
            if (h == 0) begin
                car_c[0] = HOME_C; car_r[0] = HOME_R;
                repeat (4) tick();
            end
            cars_off();
            repeat (INV + 1) tick();
        end
        set_btn(1, 1, 1, 1);
        repeat (3) tick();
        set_btn(0, 0, 0, 0);
        tick();
        press(UP);
        restart_game();

        // 256 goals: score saturates at 255
        for (int g = 0; g < 256; g++)
            repeat (HOME_R) press(UP);
        tick();

        // Reset asserted mid-respawn (counter at 5)
        car_c[0] = HOME_C; car_r[0] = HOME_R - 1;
        press(UP);
        cars_off();
        tick();
        tick();
        reset = 1'b1;
        #1;
        model_reset();
        e = snapshot();
        check("async reset", e);
        tick();
        reset = 1'b0;
        repeat (6) tick();

        // Randomised play
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 2) == 0)
                set_btn($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0);
            else
                set_btn(0, 0, 0, 0);
            restart = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) begin
                cars_off();
                for (int i = 0; i < 4; i++) begin
                    car_c[$urandom_range(0, NC-1)] = $urandom_range(0, 31);
                    car_r[$urandom_range(0, NC-1)] = $urandom_range(0, 15);
                end
            end
            tick();
        end
        restart = 1'b0;
        set_btn(0, 0, 0, 0);
        tick();

        repeat (4) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
